// File: rtl/lab2_alu_sched.sv
// lab2_alu_sched: round-robin front end that shares one lab2_alu among NREQ
// requesters. Accepted ops are registered onto the ALU inputs, tracked through
// the ALU's fixed latency, and their tagged results are queued in an in-order
// FIFO. A credit counter covering in-flight ops plus queued entries keeps the
// FIFO from ever overflowing, so alu_out never needs to be stalled or dropped.
module lab2_alu_sched #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4,
    parameter int NUM_OP  = 6,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_inputA,
    input  logic [8*NREQ-1:0]   req_inputB,
    input  logic [4*NREQ-1:0]   req_instruction,
    output logic [7:0]          alu_inputA,
    output logic [7:0]          alu_inputB,
    output logic [3:0]          alu_instruction,
    input  logic [7:0]          alu_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [7:0]          rsp_data,
    output logic                rsp_err
);

    // Tag that travels alongside an op while the ALU works on it.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
    } trk_t;

    // One queued result.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
        logic [7:0]     data;
    } ent_t;

    // Per-lane views of the packed request buses.
    logic [NREQ-1:0][7:0] lane_a;
    logic [NREQ-1:0][7:0] lane_b;
    logic [NREQ-1:0][3:0] lane_instr;
    logic [NREQ-1:0]      lane_illegal;

    assign lane_a     = req_inputA;
    assign lane_b     = req_inputB;
    assign lane_instr = req_instruction;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane_illegal[i] = (int'(lane_instr[i]) >= NUM_OP);
    end

    // State.
    logic [IDW-1:0]   last;
    logic [CW-1:0]    credits_used;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [ALU_LAT:0] vld_pipe;
    trk_t             trk_pipe [ALU_LAT+1];
    ent_t             mem [DEPTH];

    // Arbitration / handshake.
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             credit_ok;
    logic             accept;
    logic             push;
    logic             pop;
    ent_t             head;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        gnt_idx   = last;
        gnt_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
        if (gnt_found) grant[gnt_idx] = 1'b1;
    end

    // Credit check uses registered state only; a pop this cycle frees its
    // credit at the next edge, which keeps rsp_ready off the req_ready path.
    // Ready is held low while reset is asserted so every output reads 0.
    assign credit_ok = (credits_used < CW'(DEPTH));
    assign req_ready = (rst_n && credit_ok) ? grant : '0;
    assign accept    = |req_ready;

    assign push = vld_pipe[ALU_LAT];
    assign pop  = rsp_valid && rsp_ready;

    // Issue register: load the granted op, otherwise hold; advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_inputA      <= '0;
            alu_inputB      <= '0;
            alu_instruction <= '0;
            last            <= IDW'(NREQ - 1);
        end else if (accept) begin
            alu_inputA      <= lane_a[gnt_idx];
            alu_inputB      <= lane_b[gnt_idx];
            alu_instruction <= lane_instr[gnt_idx];
            last            <= gnt_idx;
        end
    end

    // Tracking shift register: the last stage lines up with alu_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int s = 0; s <= ALU_LAT; s++) trk_pipe[s] <= '0;
        end else begin
            vld_pipe[0]    <= accept;
            trk_pipe[0].id <= gnt_idx;
            trk_pipe[0].err <= lane_illegal[gnt_idx];
            for (int s = 1; s <= ALU_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                trk_pipe[s] <= trk_pipe[s-1];
            end
        end
    end

    // Result storage; illegal ops are stored as zero regardless of alu_out.
    // When full, a push only happens alongside a pop, so overwriting the
    // head slot on that edge is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr].id   <= trk_pipe[ALU_LAT].id;
            mem[wr_ptr].err  <= trk_pipe[ALU_LAT].err;
            mem[wr_ptr].data <= trk_pipe[ALU_LAT].err ? 8'h00 : alu_out;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credits: taken on accept, returned on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_used <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits_used <= credits_used + 1'b1;
                2'b01:   credits_used <= credits_used - 1'b1;
                default: credits_used <= credits_used;
            endcase
        end
    end

    // Response port shows the head; gated so an empty FIFO reads all zeros.
    assign head      = mem[rd_ptr];
    assign rsp_valid = (count != '0);
    assign rsp_id    = rsp_valid ? head.id   : '0;
    assign rsp_err   = rsp_valid ? head.err  : 1'b0;
    assign rsp_data  = rsp_valid ? head.data : 8'h00;

endmodule

// File: tb/tb_lab2_alu_sched.sv
// Bench for lab2_alu_sched: stub ALU with one registered stage, directed
// scenarios followed by a random phase, and a negedge monitor that checks
// arbitration, response timing and response contents against a queue model.
module tb_lab2_alu_sched;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 1;
    localparam int DEPTH   = 4;
    localparam int NUM_OP  = 6;
    localparam int IDW     = $clog2(NREQ);

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_inputA;
    logic [8*NREQ-1:0]   req_inputB;
    logic [4*NREQ-1:0]   req_instruction;
    logic [7:0]          alu_inputA;
    logic [7:0]          alu_inputB;
    logic [3:0]          alu_instruction;
    logic [7:0]          alu_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_data;
    logic                rsp_err;

    lab2_alu_sched #(
        .NREQ(NREQ), .ALU_LAT(ALU_LAT), .DEPTH(DEPTH), .NUM_OP(NUM_OP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inputA(req_inputA), .req_inputB(req_inputB),
        .req_instruction(req_instruction),
        .alu_inputA(alu_inputA), .alu_inputB(alu_inputB),
        .alu_instruction(alu_instruction), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Stub ALU: one registered stage; junk on illegal codes so zeroing shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= 8'h00;
        else if (int'(alu_instruction) < NUM_OP) alu_out <= alu_inputA + alu_inputB;
        else alu_out <= 8'hAA;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int n_acc    = 0;

    always @(posedge clk) edge_cnt++;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   rr_last = NREQ - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic            exp_v;
        logic            found;
        exp_t            e;
        int              idx;
        if (!rst_n) begin
            sb.delete();
            rr_last = NREQ - 1;
            chk("reset_alu", {req_ready, alu_inputA, alu_inputB, alu_instruction}, 32'h0);
            chk("reset_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, 32'h0);
        end else begin
            // Expected grant: first valid requester after the last winner,
            // provided fewer than DEPTH ops are outstanding.
            exp_ready = '0;
            found     = 1'b0;
            if (sb.size() < DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (rr_last + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        exp_ready[idx] = 1'b1;
                    end
                end
            end
            chk("req_ready", req_ready, exp_ready);

            exp_v = (sb.size() > 0) && (edge_cnt >= sb[0].due);
            chk("rsp_valid", rsp_valid, exp_v);

            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end

            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [3:0] ins;
                    logic [7:0] a;
                    logic [7:0] b;
                    ins   = req_instruction[4*i +: 4];
                    a     = req_inputA[8*i +: 8];
                    b     = req_inputB[8*i +: 8];
                    e.id  = i;
                    e.err = (int'(ins) >= NUM_OP);
                    e.data = e.err ? 8'h00 : 8'((int'(a) + int'(b)) % 256);
                    e.due = edge_cnt + ALU_LAT + 2;
                    sb.push_back(e);
                    grant_log.push_back(i);
                    rr_last = i;
                    n_acc++;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] ins);
        req_inputA[8*i +: 8]      = a;
        req_inputB[8*i +: 8]      = b;
        req_instruction[4*i +: 4] = ins;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // Let all outstanding ops come back; an expired bound counts as a failure.
    task automatic drain();
        int t;
        req_valid = '0;
        rsp_ready = 1'b1;
        t = 0;
        while (sb.size() > 0 && t < 50) begin
            step(1);
            t++;
        end
        chk("drain_empty", sb.size(), 0);
        step(1);
    endtask

    // Wait for the next response to be presented, bounded.
    task automatic wait_rsp(input string name);
        int t;
        t = 0;
        while (!rsp_valid && t < 20) begin
            step(1);
            t++;
        end
        chk(name, rsp_valid, 1'b1);
    endtask

    initial begin
        int acc0;
        int g0;
        rst_n           = 1'b0;
        req_valid       = '0;
        req_inputA      = '0;
        req_inputB      = '0;
        req_instruction = '0;
        rsp_ready       = 1'b1;
        #1;
        chk("por_ready", req_ready, '0);
        chk("por_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // 1. Single op, minimum latency.
        set_req(0, 8'h03, 8'h05, 4'h0);
        req_valid = 4'b0001;
        step(1);                 // accepted at E
        req_valid = '0;
        chk("t1_alu_a", alu_inputA, 8'h03);
        step(1);                 // after E+1
        chk("t1_early", rsp_valid, 1'b0);
        step(1);                 // after E+2
        chk("t1_valid", rsp_valid, 1'b1);
        chk("t1_id", rsp_id, 0);
        chk("t1_data", rsp_data, 8'h08);
        chk("t1_err", rsp_err, 1'b0);
        step(1);
        chk("t1_popped", rsp_valid, 1'b0);

        // 2. Round robin, all valid, one grant per cycle.
        drain();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'h10, 4'h0);
        g0   = grant_log.size();
        acc0 = n_acc;
        req_valid = '1;
        step(12);
        req_valid = '0;
        chk("t2_accepts", n_acc - acc0, 12);
        for (int k = 0; k < 12; k++) chk("t2_order", grant_log[g0 + k], k % NREQ);
        drain();

        // 3. Backpressure: credits cap accepts at DEPTH.
        rsp_ready = 1'b0;
        set_req(1, 8'h21, 8'h02, 4'h1);
        acc0 = n_acc;
        req_valid = 4'b0010;
        step(10);
        chk("t3_capped", n_acc - acc0, DEPTH);
        chk("t3_blocked", req_ready, '0);
        rsp_ready = 1'b1;
        step(8);
        req_valid = '0;
        chk("t3_resumed", n_acc - acc0 > DEPTH, 1'b1);
        drain();

        // 4. Illegal instruction, then the same operands legally (wraps to 0).
        set_req(2, 8'hFF, 8'h01, 4'hF);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        wait_rsp("t4_wait_bad");
        chk("t4_id", rsp_id, 2);
        chk("t4_err", rsp_err, 1'b1);
        chk("t4_data", rsp_data, 8'h00);
        step(1);
        set_req(2, 8'hFF, 8'h01, 4'h2);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        wait_rsp("t4_wait_good");
        chk("t4_err2", rsp_err, 1'b0);
        chk("t4_data2", rsp_data, 8'h00);
        drain();

        // 5. Three queued plus one in flight, then pop on the push edge.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            set_req(3, 8'(8'h40 + k), 8'h01, 4'h0);
            step(1);
        end
        req_valid = '0;
        step(1);                 // after E5: 3 queued, 1 in flight
        rsp_ready = 1'b1;
        step(1);                 // pop and push together
        chk("t5_still_valid", rsp_valid, 1'b1);
        drain();

        // 6. Asynchronous reset with ops in flight and queued.
        rsp_ready = 1'b0;
        set_req(0, 8'h11, 8'h22, 4'h0);
        req_valid = 4'b0001;
        step(4);
        req_valid = '1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_alu", {req_ready, alu_inputA, alu_inputB, alu_instruction}, 32'h0);
        chk("t6_async_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, 32'h0);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("t6_first_grant", req_ready, 4'b0001);
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h30 + i), 8'h03, 4'h0);
        step(8);
        drain();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
